fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Instruction fetch stage upstream of the processor-side port of the L1 cache.
// - Requests 64-byte lines over the Sysbus request/response handshake and receives 8 x 64-bit beats.
// - Splits each beat into two 32-bit instructions and buffers them in order, with their PCs, for decode.
// - Supports a redirect (branch/jump) that flushes the buffer and restarts fetch at a new PC.
// PARAMETERS
// - BUS_DATA_WIDTH  64      bus address/data width
// - BUS_TAG_WIDTH   13      request/response tag width
// - RESET_PC        64'h0   first fetch PC after reset
// - IBUF_DEPTH      32      instruction buffer entries; power of 2, >= 16
// PORTS
// - clk            in   1   clock, all state on rising edge
// - reset          in   1   asynchronous, active-high reset
// - bus_reqcyc     out  1   line request valid
// - bus_reqack     in   1   cache accepted request
// - bus_req        out  64  line address, low 6 bits zero
// - bus_reqtag     out  13  request tag
// - bus_respcyc    in   1   response beat valid
// - bus_respack    out  1   beat consumed
// - bus_resp       in   64  beat data
// - bus_resptag    in   13  response tag
// - redirect_valid in   1   flush and refetch
// - redirect_pc    in   64  new PC, 4-byte aligned
// - inst_valid     out  1   buffer head valid
// - inst_ready     in   1   decode takes head
// - inst           out  32  instruction at head
// - inst_pc        out  64  PC of head
// - fetch_err      out  1   sticky tag-mismatch flag (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): state IDLE, pc=RESET_PC, tag counter 0, buffer empty, drop flag 0.
//   Outputs bus_reqcyc, bus_respack, inst_valid, fetch_err read 0; bus_req and bus_reqtag read 0.
// - States:
//   - IDLE: if free entries >= 16 and no redirect this cycle, go to REQ.
//   - REQ: bus_reqcyc=1; bus_req={pc[63:6],6'b0}; bus_reqtag=tag counter.
//     Address and tag stay stable until bus_reqack is sampled 1, then go to RECV, beat cnt=0, tag counter+1 (wraps).
//   - RECV: bus_respack=bus_respcyc (combinational, same cycle).
//     Each acked beat pushes bits [31:0] (PC line_base+8*cnt), then bits [63:32] (PC +4).
//     Slots with PC < pc are skipped, which covers an unaligned entry into the line.
//     On the beat with cnt==7: pc=next line base, go to IDLE.
// - Space rule: a request issues only when >= 16 entries are free, so no beat is ever stalled.
// - Buffer: FIFO; 2 pushes/cycle max, 1 pop when inst_valid && inst_ready; push and pop in the same cycle is legal.
//   inst/inst_pc are valid while inst_valid=1.
// - Redirect, sampled on a clock edge:
//   - Buffer cleared; any pop that cycle is ignored; pc=redirect_pc.
//   - In IDLE: fetch restarts next cycle per IDLE rule.
//   - In REQ: the request is not retracted. bus_reqcyc stays high until ack, the drop flag is set, and all 8 beats are acked and discarded.
//   - In RECV: the drop flag is set and the remaining beats are acked and discarded.
//   - When the discarded line completes: drop flag cleared, pc unchanged (already redirect_pc).
//   - A second redirect during a drain only updates pc.
// - Latency (hit, no stall): request ack at edge N -> first beat earliest cycle N+1 -> inst_valid the cycle after that beat.
// - bus_respcyc outside RECV is ignored, with respack=0.
// CONFIGURATION
// - FETCH_TAG_CHECK_EN defined: in RECV, a beat with bus_resptag != the outstanding tag is still acked.
//   That beat is not pushed, does not advance cnt, and sets fetch_err=1 until reset.
// - FETCH_TAG_CHECK_EN undefined: bus_resptag is ignored and fetch_err is tied to 0.
// STRUCTURE
// - fetch_pkg: state enum {IDLE,REQ,RECV}, LINE_BYTES=64, LINE_BEATS=8, INSTS_PER_BEAT=2, inst entry struct {pc, inst}.
// - Sub-module inst_fifo: 2-write/1-read FIFO with synchronous flush, free count output, and async reset.
// TESTING
// - Reset, RESET_PC=0x1000, bus_reqack after 2 cycles -> bus_req=0x1000, tag 0.
//   8 beats 0x00000001_00000000.. -> 16 insts, PCs 0x1000..0x103C in order, low half first.
// - Redirect to 0x2038 in IDLE -> bus_req=0x2000; only 2 insts from beat 7 are delivered (PC 0x2038, 0x203C); next request is 0x2040.
// - Hold inst_ready=0 with IBUF_DEPTH=32 -> exactly 2 lines requested, then bus_reqcyc stays 0.
//   Pop 1 entry -> still no request until 16 are free.
// - Redirect during RECV after beat 3 -> buffer empties the next cycle; beats 4-7 are acked and not delivered.
//   Next bus_req is the redirect line, with the tag incremented.
// - Assert reset during RECV -> on the next sampled cycle bus_respack and inst_valid are 0, and fetch restarts at RESET_PC with tag 0.
// - With FETCH_TAG_CHECK_EN: a beat with a wrong tag -> acked, fetch_err=1, and 16 instructions are still delivered after 8 good beats.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   fetch_state_e  : fetch sequencer states
//   LINE_*         : cache line geometry on the Sysbus
//   inst_entry_t   : one buffered instruction with its PC
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV
  } fetch_state_e;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned LINE_BEATS     = 8;
  localparam int unsigned INSTS_PER_BEAT = 2;
  // A line is only requested when every slot it can produce fits in the buffer.
  localparam int unsigned REQ_MIN_FREE   = LINE_BEATS * INSTS_PER_BEAT;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } inst_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Sysbus line request/response handshake between the fetch stage and the L1.
//   reqcyc/reqack/req/reqtag     : line request (master drives cyc/addr/tag)
//   respcyc/respack/resp/resptag : response beats (slave drives cyc/data/tag)
// Modports: master = fetch unit, slave = cache/bus model.
interface fetch_unit_if #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13
);
  logic                      reqcyc;
  logic                      reqack;
  logic [BUS_DATA_WIDTH-1:0] req;
  logic [BUS_TAG_WIDTH-1:0]  reqtag;
  logic                      respcyc;
  logic                      respack;
  logic [BUS_DATA_WIDTH-1:0] resp;
  logic [BUS_TAG_WIDTH-1:0]  resptag;

  modport master (
    output reqcyc, req, reqtag, respack,
    input  reqack, respcyc, resp, resptag
  );

  modport slave (
    input  reqcyc, req, reqtag, respack,
    output reqack, respcyc, resp, resptag
  );
endinterface

// File: rtl/fetch_unit_inst_fifo.sv
// inst_fifo: in-order instruction buffer, up to two pushes and one pop per cycle.
//   clk, reset     : clock, asynchronous active-high reset
//   flush          : synchronous clear, wins over same-cycle push/pop
//   push0/data0    : first (older) write slot
//   push1/data1    : second write slot, lands after data0 when both are set
//   pop            : remove head (ignored when empty)
//   valid/head     : head entry and its validity
//   free           : number of unused entries
module inst_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push0,
  input  inst_entry_t              data0,
  input  logic                     push1,
  input  inst_entry_t              data1,
  input  logic                     pop,
  output logic                     valid,
  output inst_entry_t              head,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);

  inst_entry_t     mem [DEPTH];
  logic [AW:0]     wptr, rptr, count, n_push;
  logic [AW-1:0]   widx0, widx1;

  assign count  = wptr - rptr;
  assign valid  = (count != '0);
  assign free   = (AW+1)'(DEPTH) - count;
  assign head   = mem[rptr[AW-1:0]];
  assign n_push = (AW+1)'(push0) + (AW+1)'(push1);
  assign widx0  = wptr[AW-1:0];
  // data1 follows data0 only when data0 is actually written this cycle.
  assign widx1  = push0 ? (widx0 + AW'(1)) : widx0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + n_push;
      if (pop && valid) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push0) mem[widx0] <= data0;
      if (push1) mem[widx1] <= data1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Requests 64-byte lines over Sysbus,
// splits each 64-bit beat into two instructions (low half first) and queues
// them with their PCs for decode. A redirect flushes the queue and restarts
// fetch; a line already in flight is acked to completion and discarded.
//   clk, reset               : clock, asynchronous active-high reset
//   bus (fetch_unit_if.master): line request / response beats
//   redirect_valid/_pc       : flush and refetch at a new 4-byte aligned PC
//   inst_valid/ready/inst/pc : decode-side head of the buffer
//   fetch_err                : sticky response tag mismatch
// Build option: define FETCH_TAG_CHECK_EN to check response tags; otherwise
// bus.resptag is ignored and fetch_err is tied low.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned                BUS_DATA_WIDTH = 64,
  parameter int unsigned                BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_DATA_WIDTH-1:0]  RESET_PC       = '0,
  parameter int unsigned                IBUF_DEPTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  fetch_unit_if.master              bus,
  input  logic                      redirect_valid,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [BUS_DATA_WIDTH-1:0] inst_pc,
  output logic                      fetch_err
);

  localparam int unsigned DW     = BUS_DATA_WIDTH;
  localparam int unsigned FREE_W = $clog2(IBUF_DEPTH) + 1;

  fetch_state_e             state, state_next;
  logic [DW-1:0]            pc, req_addr, slot_pc0, slot_pc1;
  logic [BUS_TAG_WIDTH-1:0] tag_cnt, out_tag;
  logic [2:0]               beat_cnt;
  logic                     drop;
  logic [FREE_W-1:0]        free;
  logic                     beat_ack, tag_ok, beat_good, line_done;
  logic                     push0, push1;
  inst_entry_t              ent0, ent1, head;

  assign beat_ack = (state == RECV) && bus.respcyc;

`ifdef FETCH_TAG_CHECK_EN
  logic err;
  assign tag_ok    = (bus.resptag == out_tag);
  assign fetch_err = err;
`else
  logic unused_tag;
  assign tag_ok     = 1'b1;
  assign fetch_err  = 1'b0;
  assign unused_tag = ^{bus.resptag, out_tag};
`endif

  assign beat_good = beat_ack && tag_ok;
  assign line_done = beat_good && (beat_cnt == 3'(LINE_BEATS - 1));

  // Slots below the current pc belong to an unaligned entry into the line.
  assign slot_pc0 = req_addr + DW'({beat_cnt, 3'b000});
  assign slot_pc1 = slot_pc0 + DW'(4);
  assign push0    = beat_good && !drop && !redirect_valid && (slot_pc0 >= pc);
  assign push1    = beat_good && !drop && !redirect_valid && (slot_pc1 >= pc);
  assign ent0     = '{pc: slot_pc0, inst: bus.resp[31:0]};
  assign ent1     = '{pc: slot_pc1, inst: bus.resp[63:32]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    bus.reqcyc  = 1'b0;
    bus.req     = '0;
    bus.reqtag  = '0;
    bus.respack = 1'b0;
    unique case (state)
      IDLE: if (free >= FREE_W'(REQ_MIN_FREE) && !redirect_valid) state_next = REQ;
      REQ: begin
        bus.reqcyc = 1'b1;
        bus.req    = req_addr;
        bus.reqtag = tag_cnt;
        if (bus.reqack) state_next = RECV;
      end
      RECV: begin
        bus.respack = bus.respcyc;
        if (line_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      req_addr <= '0;
      tag_cnt  <= '0;
      out_tag  <= '0;
      beat_cnt <= '0;
      drop     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (state_next == REQ) req_addr <= {pc[DW-1:6], 6'b0};
        REQ: if (bus.reqack) begin
          out_tag  <= tag_cnt;
          tag_cnt  <= tag_cnt + BUS_TAG_WIDTH'(1);
          beat_cnt <= '0;
        end
        RECV: begin
          if (beat_good) beat_cnt <= beat_cnt + 3'd1;
          if (line_done) begin
            drop <= 1'b0;
            // A drained line leaves pc at the redirect target.
            if (!drop) pc <= req_addr + DW'(LINE_BYTES);
          end
        end
        default: ;
      endcase
      // A redirect on the final beat needs no drain: that line is done anyway.
      if (redirect_valid) begin
        pc <= redirect_pc;
        if (state == REQ || (state == RECV && !line_done)) drop <= 1'b1;
      end
    end
  end

`ifdef FETCH_TAG_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   err <= 1'b0;
    else if (beat_ack && !tag_ok) err <= 1'b1;
  end
`endif

  inst_fifo #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push0 (push0),
    .data0 (ent0),
    .push1 (push1),
    .data1 (ent1),
    .pop   (inst_valid && inst_ready),
    .valid (inst_valid),
    .head  (head),
    .free  (free)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The expected instruction stream is built
// from line address, fetch target and beat data; a monitor compares the
// buffer head against it every cycle while the outputs are meaningful.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  fetch_unit_if #(.BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13)) bus ();

  fetch_unit #(
    .BUS_DATA_WIDTH(64),
    .BUS_TAG_WIDTH (13),
    .RESET_PC      (64'h1000),
    .IBUF_DEPTH    (32)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .fetch_err     (fetch_err)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  localparam int unsigned NONE = 99;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 64'(act), 64'(exp));
  endtask

  // Word k of a line is salt+k; slot k sits at line+4k and is delivered
  // only if it is at or past the fetch target.
  function automatic void model_line(input logic [63:0] line, input logic [63:0] target,
                                     input logic [31:0] salt);
    for (int unsigned k = 0; k < 16; k++) begin
      exp_t e;
      e.pc   = line + 64'(4 * k);
      e.word = salt + 32'(k);
      if (e.pc >= target) exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset || redirect_valid) begin
        exp_q.delete();
      end else if (inst_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL inst_unexpected: got pc %h inst %h expected no instruction", inst_pc, inst);
        end else begin
          chk("inst_pc", inst_pc, exp_q[0].pc);
          chk("inst", 64'(inst), 64'(exp_q[0].word));
          if (inst_ready) void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic wait_req(input logic [63:0] addr, input logic [12:0] tag, input int unsigned dly,
                          input bit redir, input logic [63:0] rpc);
    int unsigned n = 0;
    @(negedge clk);
    while (!bus.reqcyc && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1("req_seen", bus.reqcyc, 1'b1);
    chk("req_addr", bus.req, addr);
    chk("req_tag", 64'(bus.reqtag), 64'(tag));
    for (int unsigned i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_hold_addr", bus.req, addr);
      chk("req_hold_tag", 64'(bus.reqtag), 64'(tag));
    end
    if (redir) begin
      tick();
      redirect_pc    = rpc;
      redirect_valid = 1'b1;
      tick();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk1("req_not_retracted", bus.reqcyc, 1'b1);
      chk("req_redir_addr", bus.req, addr);
    end
    tick();
    bus.reqack = 1'b1;
    tick();
    bus.reqack = 1'b0;
  endtask

  task automatic send_beats(input logic [31:0] salt, input int unsigned first, input int unsigned last,
                            input logic [12:0] tag, input int unsigned bad_at);
    for (int unsigned b = first; b <= last; b++) begin
      if (b == bad_at) begin
        bus.respcyc = 1'b1;
        bus.resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.resptag = tag ^ 13'h1;
        @(negedge clk);
        chk1("bad_beat_ack", bus.respack, 1'b1);
        tick();
      end
      bus.respcyc = 1'b1;
      bus.resp    = {salt + 32'(2 * b + 1), salt + 32'(2 * b)};
      bus.resptag = tag;
      @(negedge clk);
      chk1("beat_ack", bus.respack, 1'b1);
      tick();
    end
    bus.respcyc = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    bus.reqack     = 1'b0;
    bus.respcyc    = 1'b0;
    bus.resp       = '0;
    bus.resptag    = '0;
    repeat (2) @(negedge clk);
    chk1("rst_reqcyc", bus.reqcyc, 1'b0);
    chk1("rst_respack", bus.respack, 1'b0);
    chk1("rst_inst_valid", inst_valid, 1'b0);
    chk1("rst_fetch_err", fetch_err, 1'b0);
    chk("rst_req", bus.req, 64'd0);
    chk("rst_reqtag", 64'(bus.reqtag), 64'd0);
    tick();
    reset = 1'b0;

    // First line from RESET_PC, buffer not drained.
    model_line(64'h1000, 64'h1000, 32'h0);
    chk("model_n", 64'(exp_q.size()), 64'd16);
    chk("model_first_pc", exp_q[0].pc, 64'h1000);
    chk("model_first_inst", 64'(exp_q[0].word), 64'h0);
    chk("model_second_inst", 64'(exp_q[1].word), 64'h1);
    chk("model_last_pc", exp_q[15].pc, 64'h103C);
    wait_req(64'h1000, 13'd0, 2, 1'b0, '0);
    send_beats(32'h0, 0, 7, 13'd0, NONE);
    model_line(64'h1040, 64'h1040, 32'h100);
    wait_req(64'h1040, 13'd1, 0, 1'b0, '0);
    send_beats(32'h100, 0, 7, 13'd1, NONE);

    // Buffer full: no more requests, stray response ignored, one pop not enough.
    repeat (20) begin
      @(negedge clk);
      chk1("no_req_full", bus.reqcyc, 1'b0);
    end
    tick();
    bus.respcyc = 1'b1;
    bus.resp    = '1;
    @(negedge clk);
    chk1("stray_resp_noack", bus.respack, 1'b0);
    tick();
    bus.respcyc = 1'b0;
    inst_ready  = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk1("no_req_one_free", bus.reqcyc, 1'b0);
    end

    // Redirect in IDLE to an unaligned PC near the end of a line.
    tick();
    redirect_pc    = 64'h2038;
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    model_line(64'h2000, 64'h2038, 32'h200);
    chk("model_unaligned_n", 64'(exp_q.size()), 64'd2);
    chk("model_unaligned_pc", exp_q[0].pc, 64'h2038);
    wait_req(64'h2000, 13'd2, 0, 1'b0, '0);
    send_beats(32'h200, 0, 7, 13'd2, NONE);
    wait_drain();

    // Redirect during RECV with beat 4 on the bus.
    model_line(64'h2040, 64'h2040, 32'h300);
    wait_req(64'h2040, 13'd3, 0, 1'b0, '0);
    send_beats(32'h300, 0, 3, 13'd3, NONE);
    redirect_pc    = 64'h3000;
    redirect_valid = 1'b1;
    send_beats(32'h300, 4, 4, 13'd3, NONE);
    redirect_valid = 1'b0;
    chk1("flush_empty", inst_valid, 1'b0);
    send_beats(32'h300, 5, 7, 13'd3, NONE);

    // Redirect while the request is pending: line acked and discarded.
    wait_req(64'h3000, 13'd4, 0, 1'b1, 64'h4010);
    send_beats(32'h400, 0, 7, 13'd4, NONE);
    model_line(64'h4000, 64'h4010, 32'h500);
    chk("model_redir_n", 64'(exp_q.size()), 64'd12);
    wait_req(64'h4000, 13'd5, 0, 1'b0, '0);
    send_beats(32'h500, 0, 7, 13'd5, NONE);
    wait_drain();

    // Reset in the middle of a line.
    model_line(64'h4040, 64'h4040, 32'h600);
    wait_req(64'h4040, 13'd6, 0, 1'b0, '0);
    send_beats(32'h600, 0, 2, 13'd6, NONE);
    bus.respcyc = 1'b1;
    bus.resp    = {32'h607, 32'h606};
    bus.resptag = 13'd6;
    #2 reset = 1'b1;
    @(negedge clk);
    chk1("rst_recv_respack", bus.respack, 1'b0);
    chk1("rst_recv_inst_valid", inst_valid, 1'b0);
    chk1("rst_recv_reqcyc", bus.reqcyc, 1'b0);
    tick();
    bus.respcyc = 1'b0;
    tick();
    reset = 1'b0;
    model_line(64'h1000, 64'h1000, 32'h700);
    wait_req(64'h1000, 13'd0, 1, 1'b0, '0);
    send_beats(32'h700, 0, 7, 13'd0, NONE);
    wait_drain();

`ifdef FETCH_TAG_CHECK_EN
    chk1("err_before", fetch_err, 1'b0);
    model_line(64'h1040, 64'h1040, 32'h800);
    wait_req(64'h1040, 13'd1, 0, 1'b0, '0);
    send_beats(32'h800, 0, 7, 13'd1, 3);
    chk1("tag_err_sticky", fetch_err, 1'b1);
    wait_drain();
    chk1("tag_err_held", fetch_err, 1'b1);
`else
    chk1("err_tied_low", fetch_err, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
